// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states, opcodes,
// datapath select encodings and the bundled control word.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } statetype_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRCB_REGB   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// plus memory port (slave).
interface multicycle_ctrl_if;
    import mips_pkg::*;

    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal_op;

    modport master (
        input  op, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op
    );

    modport slave (
        output op, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc,
               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op
    );

endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: 4-bit state register plus combinational
// next-state / control-word decode, stalling on the memory ready handshake.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_ctrl_if.master    bus
);

    statetype_t state;
    statetype_t next_state;
    ctrl_t      ctrl;
    ctrl_t      ctrl_gated;

    // Reset must silence every strobe immediately, even though the async
    // reset parks the state in FETCH, which would otherwise request memory.
    function automatic ctrl_t gate_strobes(input ctrl_t c, input logic en);
        ctrl_t g;
        g = c;
        if (!en) begin
            g.mem_req    = 1'b0;
            g.memwrite   = 1'b0;
            g.irwrite    = 1'b0;
            g.pcwrite    = 1'b0;
            g.branch     = 1'b0;
            g.regwrite   = 1'b0;
            g.illegal_op = 1'b0;
        end
        return g;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        ctrl       = CTRL_IDLE;
        unique case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUSRCB_FOUR;
                if (bus.mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    next_state   = DECODE;
                end else begin
                    next_state   = FETCH;
                end
            end
            DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMMSH2;
                case (bus.op)
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        next_state      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                next_state   = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                next_state   = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                next_state    = FETCH;
            end
            MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                next_state    = bus.mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
                next_state   = ALUWB;
            end
            ALUWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
                next_state   = FETCH;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
                next_state   = ADDIWB;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
                next_state    = FETCH;
            end
            JUMP: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
                next_state   = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign ctrl_gated = gate_strobes(ctrl, reset_n);

    assign bus.mem_req    = ctrl_gated.mem_req;
    assign bus.iord       = ctrl_gated.iord;
    assign bus.memwrite   = ctrl_gated.memwrite;
    assign bus.irwrite    = ctrl_gated.irwrite;
    assign bus.pcwrite    = ctrl_gated.pcwrite;
    assign bus.branch     = ctrl_gated.branch;
    assign bus.pcsrc      = ctrl_gated.pcsrc;
    assign bus.alusrca    = ctrl_gated.alusrca;
    assign bus.alusrcb    = ctrl_gated.alusrcb;
    assign bus.aluop      = ctrl_gated.aluop;
    assign bus.regdst     = ctrl_gated.regdst;
    assign bus.memtoreg   = ctrl_gated.memtoreg;
    assign bus.regwrite   = ctrl_gated.regwrite;
    assign bus.illegal_op = ctrl_gated.illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-written expected
// control words per cycle, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

    logic clk;
    logic reset_n;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word packing: {mem_req, iord, memwrite, irwrite, pcwrite, branch,
    // pcsrc[1:0], alusrca, alusrcb[1:0], aluop[1:0], regdst, memtoreg, regwrite, illegal_op}
    localparam logic [16:0] MREQ  = 17'd1 << 16;
    localparam logic [16:0] IORD  = 17'd1 << 15;
    localparam logic [16:0] MW    = 17'd1 << 14;
    localparam logic [16:0] IRW   = 17'd1 << 13;
    localparam logic [16:0] PCW   = 17'd1 << 12;
    localparam logic [16:0] BRB   = 17'd1 << 11;
    localparam logic [16:0] PC_AO = 17'd1 << 9;
    localparam logic [16:0] PC_J  = 17'd2 << 9;
    localparam logic [16:0] ASA   = 17'd1 << 8;
    localparam logic [16:0] B_4   = 17'd1 << 6;
    localparam logic [16:0] B_IM  = 17'd2 << 6;
    localparam logic [16:0] B_IS  = 17'd3 << 6;
    localparam logic [16:0] OP_SB = 17'd1 << 4;
    localparam logic [16:0] OP_FN = 17'd2 << 4;
    localparam logic [16:0] RDST  = 17'd1 << 3;
    localparam logic [16:0] MTOR  = 17'd1 << 2;
    localparam logic [16:0] RW    = 17'd1 << 1;
    localparam logic [16:0] ILL   = 17'd1;

    localparam logic [16:0] ALL     = 17'h1FFFF;
    localparam logic [16:0] STROBES = MREQ | MW | IRW | PCW | BRB | RW | ILL;

    localparam logic [16:0] E_FETCH_GO = MREQ | IRW | PCW | B_4;
    localparam logic [16:0] E_FETCH_WT = MREQ | B_4;
    localparam logic [16:0] E_DECODE   = B_IS;
    localparam logic [16:0] E_MEMADR   = ASA | B_IM;
    localparam logic [16:0] E_MEMRD    = MREQ | IORD;
    localparam logic [16:0] E_MEMWB    = MTOR | RW;
    localparam logic [16:0] E_MEMWR    = MREQ | IORD | MW;
    localparam logic [16:0] E_EXEC     = ASA | OP_FN;
    localparam logic [16:0] E_ALUWB    = RDST | RW;
    localparam logic [16:0] E_BRANCH   = ASA | OP_SB | PC_AO | BRB;
    localparam logic [16:0] E_ADDIEX   = ASA | B_IM;
    localparam logic [16:0] E_ADDIWB   = RW;
    localparam logic [16:0] E_JUMP     = PC_J | PCW;
    localparam logic [16:0] E_ILLEGAL  = B_IS | ILL;

    localparam logic [5:0] O_R   = 6'b000000;
    localparam logic [5:0] O_LW  = 6'b100011;
    localparam logic [5:0] O_SW  = 6'b101011;
    localparam logic [5:0] O_BEQ = 6'b000100;
    localparam logic [5:0] O_ADI = 6'b001000;
    localparam logic [5:0] O_J   = 6'b000010;
    localparam logic [5:0] O_BAD = 6'b111111;

    typedef struct {
        logic [16:0] val;
        logic [16:0] mask;
        string       tag;
    } exp_t;

    exp_t expq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [16:0] actual;
    assign actual = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcwrite,
                     bus.branch, bus.pcsrc, bus.alusrca, bus.alusrcb, bus.aluop,
                     bus.regdst, bus.memtoreg, bus.regwrite, bus.illegal_op};

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            n_cmp = n_cmp + 1;
            if ((actual & e.mask) !== (e.val & e.mask)) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got %b, expected %b (mask %b)",
                         e.tag, actual & e.mask, e.val & e.mask, e.mask);
            end
        end
    end

    task automatic step(input logic rn, input logic [5:0] o, input logic rdy,
                        input logic [16:0] val, input logic [16:0] mask, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n       = rn;
        bus.op        = o;
        bus.mem_ready = rdy;
        e.val  = val;
        e.mask = mask;
        e.tag  = tag;
        expq.push_back(e);
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.op        = O_R;
        bus.mem_ready = 1'b1;

        step(1'b0, O_ADI, 1'b1, 17'd0, STROBES, "reset_a");
        step(1'b0, O_ADI, 1'b1, 17'd0, STROBES, "reset_b");

        step(1'b1, O_ADI, 1'b1, E_FETCH_GO, ALL, "addi_fetch");
        step(1'b1, O_ADI, 1'b1, E_DECODE,   ALL, "addi_decode");
        step(1'b1, O_ADI, 1'b1, E_ADDIEX,   ALL, "addi_ex");
        step(1'b1, O_ADI, 1'b1, E_ADDIWB,   ALL, "addi_wb");

        step(1'b1, O_R, 1'b0, E_FETCH_WT, ALL, "r_fetch_wait");
        step(1'b1, O_R, 1'b1, E_FETCH_GO, ALL, "r_fetch");
        step(1'b1, O_R, 1'b0, E_DECODE,   ALL, "r_decode");
        step(1'b1, O_R, 1'b0, E_EXEC,     ALL, "r_exec");
        step(1'b1, O_R, 1'b1, E_ALUWB,    ALL, "r_wb");

        step(1'b1, O_LW, 1'b1, E_FETCH_GO, ALL, "lw_fetch");
        step(1'b1, O_LW, 1'b1, E_DECODE,   ALL, "lw_decode");
        step(1'b1, O_LW, 1'b1, E_MEMADR,   ALL, "lw_memadr");
        step(1'b1, O_LW, 1'b0, E_MEMRD,    ALL, "lw_memrd_w1");
        step(1'b1, O_LW, 1'b0, E_MEMRD,    ALL, "lw_memrd_w2");
        step(1'b1, O_LW, 1'b1, E_MEMRD,    ALL, "lw_memrd_go");
        step(1'b1, O_LW, 1'b0, E_MEMWB,    ALL, "lw_memwb");

        step(1'b1, O_SW, 1'b1, E_FETCH_GO, ALL, "sw_fetch");
        step(1'b1, O_SW, 1'b1, E_DECODE,   ALL, "sw_decode");
        step(1'b1, O_SW, 1'b0, E_MEMADR,   ALL, "sw_memadr");
        step(1'b1, O_SW, 1'b0, E_MEMWR,    ALL, "sw_memwr_wait");
        step(1'b0, O_SW, 1'b0, 17'd0,      STROBES, "sw_reset_drop");
        step(1'b0, O_SW, 1'b1, 17'd0,      STROBES, "sw_reset_hold");

        step(1'b1, O_BEQ, 1'b1, E_FETCH_GO, ALL, "beq_fetch");
        step(1'b1, O_BEQ, 1'b1, E_DECODE,   ALL, "beq_decode");
        step(1'b1, O_BEQ, 1'b1, E_BRANCH,   ALL, "beq_branch");

        step(1'b1, O_J, 1'b1, E_FETCH_GO, ALL, "j_fetch");
        step(1'b1, O_J, 1'b1, E_DECODE,   ALL, "j_decode");
        step(1'b1, O_J, 1'b1, E_JUMP,     ALL, "j_jump");

        step(1'b1, O_BAD, 1'b1, E_FETCH_GO, ALL, "ill_fetch");
        step(1'b1, O_BAD, 1'b1, E_ILLEGAL,  ALL, "ill_decode");
        step(1'b1, O_BAD, 1'b1, E_FETCH_GO, ALL, "ill_next_fetch");
        step(1'b1, O_BAD, 1'b1, E_ILLEGAL,  ALL, "ill_decode_again");
        step(1'b1, O_R,   1'b1, E_FETCH_GO, ALL, "ill_pulse_once");

        @(negedge clk);
        #1;
        n_cmp = n_cmp + 1;
        if (expq.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL queue_drain: %0d entries left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle MIPS core; it sequences a shared-ALU, single-memory datapath through the fetch, decode, execute, memory and writeback steps. It decodes the 6-bit opcode from the instruction register into per-cycle mux selects and write strobes. It also stalls on a ready/request memory handshake. Function-code decoding stays in the existing ALU decoder, which consumes `aluop`.

## Interface
- No parameters.
- `clk  in  1`  rising-edge clock.
- `reset_n  in  1`  asynchronous, active-low reset.
- `op  in  6`  opcode from the instruction register, i.e. instr[31:26].
- `mem_ready  in  1`  memory completes the current access this cycle.
- `mem_req  out  1`  memory access requested.
- `iord  out  1`  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite  out  1`  store strobe, qualified by `mem_req`.
- `irwrite  out  1`  instruction register load enable.
- `pcwrite  out  1`  unconditional PC load.
- `branch  out  1`  conditional PC load; the datapath computes pcen = pcwrite | (branch & zero).
- `pcsrc  out  2`  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alusrca  out  1`  ALU A select: 0 = PC, 1 = register A.
- `alusrcb  out  2`  ALU B select: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `aluop  out  2`  ALU operation: 00 = add, 01 = subtract, 10 = use funct field.
- `regdst  out  1`  write register: 0 = rt, 1 = rd.
- `memtoreg  out  1`  writeback data: 0 = ALUOut, 1 = memory data.
- `regwrite  out  1`  register file write strobe.
- `illegal_op  out  1`  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- The state register is 4 bits and is the only storage element. Outputs are a combinational decode of the state, with `mem_ready` gating in the memory states.
- Unless a state lists a signal, strobes are 0 and selects are 0.
- States, outputs and transitions:
  - FETCH: mem_req=1, alusrcb=01. When mem_ready=1: irwrite=1, pcwrite=1, go to DECODE. Otherwise stay, with irwrite=0 and pcwrite=0.
  - DECODE: alusrcb=11. Next state by op:
    - 000000 → EXECUTE
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - any other op → FETCH, with illegal_op=1 for this cycle.
  - MEMADR: alusrca=1, alusrcb=10. If op=100011 go to MEMRD, otherwise MEMWR.
  - MEMRD: mem_req=1, iord=1. Go to MEMWB when mem_ready=1, otherwise stay.
  - MEMWB: memtoreg=1, regwrite=1. Go to FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=1. Go to FETCH when mem_ready=1, otherwise stay.
  - EXECUTE: alusrca=1, aluop=10. Go to ALUWB.
  - ALUWB: regdst=1, regwrite=1. Go to FETCH.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1. Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10. Go to ADDIWB.
  - ADDIWB: regwrite=1. Go to FETCH.
  - JUMP: pcsrc=10, pcwrite=1. Go to FETCH.
- Unused state encodings (12–15) go to FETCH on the next edge, and all their outputs are 0.
- `op` is sampled only in DECODE and MEMADR. The instruction register is stable in both, because irwrite is asserted only in FETCH.

## Timing
- Reset asynchronously forces the state to FETCH. While reset_n=0, all strobes are 0 regardless of mem_ready: mem_req, memwrite, irwrite, pcwrite, branch, regwrite, illegal_op.
- The first mem_req is asserted in the cycle after reset_n deasserts.
- Cycles per instruction with zero memory wait (mem_ready held at 1):
  - R-type: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - ADDI: 4
  - J: 3
  - Illegal opcode: 2
- Each memory wait cycle adds exactly 1 cycle in FETCH, MEMRD or MEMWR.
- mem_req/iord/memwrite are held stable across wait cycles until the cycle in which mem_ready=1.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Reset asserted mid-access drops mem_req and memwrite immediately (combinationally). No partial writeback or PC update occurs.

## Structure
- The shared package `mips_pkg` holds:
  - the state enum `statetype_t`, with encodings FETCH=0 through JUMP=11;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - named constants for the alusrcb, pcsrc and aluop encodings.
- The block is a single module, built as a state register plus a next-state/output decode. It has no sub-module.
- The ALU decoder is instantiated beside this block by the parent controller.

## Test plan
- Reset: reset_n=0 with mem_ready=1 → all strobes 0. After release: FETCH, with mem_req=1 and, since mem_ready=1, irwrite=1 and pcwrite=1 in the first cycle.
- ADDI (op=001000), mem_ready=1 → states FETCH, DECODE, ADDIEX, ADDIWB. regwrite=1 only in cycle 4, with regdst=0 and memtoreg=0.
- LW with mem_ready low for 2 cycles in MEMRD → LW takes 7 cycles total. iord=1 held for 3 cycles. MEMWB asserts memtoreg=1 and regwrite=1.
- SW, then reset_n pulsed low during the MEMWR wait → memwrite drops in the same cycle. After release: state FETCH, regwrite never asserted.
- BEQ, then J → BEQ cycle 3 shows branch=1, pcsrc=01, aluop=01. J cycle 3 shows pcwrite=1, pcsrc=10.
- op=111111 → illegal_op=1 for exactly one cycle in DECODE, no register or memory write, next state FETCH.
